// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the instruction fetch path.
//   NOP            : instruction presented to decode when nothing is queued
//   DEFAULT_DEPTH  : default number of instruction queue entries
//   fetch_state_t  : fetch handshake states (IDLE / WAIT_RESP / DROP)
//   fetch_entry_t  : one queued fetch result {pc, instr}
package pipe_pkg;

    localparam logic [31:0] NOP           = 32'h0000_0013;
    localparam int          DEFAULT_DEPTH = 2;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_RESP = 2'd1,
        DROP      = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue storage for the fetch buffer.
//   i_Clk, i_Reset : clock, asynchronous active-low reset
//   push/push_data : write one {pc, instr} entry (ignored while full)
//   pop            : drop the head entry (ignored while empty)
//   flush          : clear pointers and count; wins over push and pop
//   head_data      : registered head entry (undefined while empty)
//   full/empty/count : occupancy
module fetch_fifo
    import pipe_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             i_Clk,
    input  logic             i_Reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             flush,
    output fetch_entry_t     head_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    // NOTE: sequential state is updated only with non-blocking assignments.
    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= ptr_inc(wr_ptr);
            if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

    // NOTE: the storage array has no reset; its contents only become visible
    // once count says they were written, and the top masks the head while empty.
    always_ff @(posedge i_Clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_data;
    end

    assign head_data = mem[rd_ptr];

endmodule

// File: rtl/fetch_buffer.sv
// Fetch buffer: issues one instruction-memory request at a time, queues the
// returned words with their PCs and hands them to decode.
//   i_Clk, i_Reset                    : clock, asynchronous active-low reset
//   i_PCF, o_StallF                   : fetch PC in; PC register hold out
//   i_FlushF                          : redirect, discards queued and in-flight fetches
//   o_MemReq/o_MemAddr/i_MemReady     : request handshake
//   i_MemRValid/i_MemRData            : read response
//   i_StallD                          : decode not ready
//   o_InstrValid/o_InstrD/o_PCD       : queue head to decode
module fetch_buffer
    import pipe_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic        i_Clk,
    input  logic        i_Reset,
    input  logic [31:0] i_PCF,
    input  logic        i_FlushF,
    output logic        o_StallF,
    output logic        o_MemReq,
    output logic [31:0] o_MemAddr,
    input  logic        i_MemReady,
    input  logic        i_MemRValid,
    input  logic [31:0] i_MemRData,
    input  logic        i_StallD,
    output logic        o_InstrValid,
    output logic [31:0] o_InstrD,
    output logic [31:0] o_PCD
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_t     state;
    fetch_state_t     next_state;
    logic [31:0]      req_pc;
    logic             mem_req;
    logic             accept;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    fetch_entry_t     head;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        mem_req    = 1'b0;
        push       = 1'b0;
        unique case (state)
            IDLE: begin
                // Issuing only below DEPTH reserves a slot for the response.
                // Gating with reset keeps the request quiet while reset is held.
                mem_req = i_Reset && !i_FlushF && (count < CNT_W'(DEPTH));
                if (mem_req && i_MemReady) next_state = WAIT_RESP;
            end
            WAIT_RESP: begin
                if (i_FlushF) begin
                    // A response arriving with the flush is simply dropped.
                    next_state = i_MemRValid ? IDLE : DROP;
                end else if (i_MemRValid) begin
                    push       = 1'b1;
                    next_state = IDLE;
                end
            end
            DROP: begin
                // Swallow the orphaned response; a new flush just keeps waiting.
                if (i_MemRValid) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge i_Clk or negedge i_Reset) begin
        if (!i_Reset) begin
            state  <= IDLE;
            req_pc <= '0;
        end else begin
            state <= next_state;
            if (accept) req_pc <= i_PCF;
        end
    end

    assign accept    = mem_req & i_MemReady;
    assign o_MemReq  = mem_req;
    assign o_MemAddr = i_PCF;
    assign o_StallF  = ~accept;
    assign pop       = ~empty & ~i_StallD;

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_Clk     (i_Clk),
        .i_Reset   (i_Reset),
        .push      (push),
        .push_data (fetch_entry_t'{pc: req_pc, instr: i_MemRData}),
        .pop       (pop),
        .flush     (i_FlushF),
        .head_data (head),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    assign o_InstrValid = ~empty;
    assign o_InstrD     = empty ? NOP : head.instr;
    assign o_PCD        = empty ? 32'h0 : head.pc;

    // A response always has a reserved slot, so a push can never meet a full queue.
    always_ff @(posedge i_Clk) begin
        if (i_Reset && push) assert (!full);
    end

endmodule

// File: tb/tb_fetch_buffer.sv
module tb_fetch_buffer;
    import pipe_pkg::*;

    localparam int DEPTH = 2;

    logic        i_Clk = 1'b0;
    logic        i_Reset = 1'b0;
    logic [31:0] i_PCF = '0;
    logic        i_FlushF = 1'b0;
    logic        o_StallF;
    logic        o_MemReq;
    logic [31:0] o_MemAddr;
    logic        i_MemReady = 1'b0;
    logic        i_MemRValid = 1'b0;
    logic [31:0] i_MemRData = '0;
    logic        i_StallD = 1'b0;
    logic        o_InstrValid;
    logic [31:0] o_InstrD;
    logic [31:0] o_PCD;

    fetch_buffer #(.DEPTH(DEPTH)) dut (
        .i_Clk        (i_Clk),
        .i_Reset      (i_Reset),
        .i_PCF        (i_PCF),
        .i_FlushF     (i_FlushF),
        .o_StallF     (o_StallF),
        .o_MemReq     (o_MemReq),
        .o_MemAddr    (o_MemAddr),
        .i_MemReady   (i_MemReady),
        .i_MemRValid  (i_MemRValid),
        .i_MemRData   (i_MemRData),
        .i_StallD     (i_StallD),
        .o_InstrValid (o_InstrValid),
        .o_InstrD     (o_InstrD),
        .o_PCD        (o_PCD)
    );

    always #5 i_Clk = ~i_Clk;

    int checks = 0;
    int errors = 0;

    // Scoreboard of {pc, instr} that decode should see, in order.
    logic [63:0] exp_q[$];

    // Environment: PC register, memory model and per-cycle controls.
    logic [31:0] pcf;
    logic        ready, stall_d, flush;
    int          latency;
    logic        mem_busy, mem_stale;
    int          mem_cnt;
    logic [31:0] mem_pc, mem_data;
    logic        use_forced;
    logic [31:0] forced_data;
    int          pops;

    // Observations from the most recent cycle.
    logic        smp_req, smp_acc, smp_valid, smp_rvalid, smp_stallf;
    logic [31:0] smp_addr;

    // One clock cycle: drive inputs, sample on the falling edge, update the
    // memory model and scoreboard, then step past the rising edge.
    task automatic tick();
        i_PCF       = pcf;
        i_MemReady  = ready;
        i_StallD    = stall_d;
        i_FlushF    = flush;
        i_MemRValid = mem_busy && (mem_cnt == 0);
        i_MemRData  = i_MemRValid ? mem_data : $urandom();
        @(negedge i_Clk);
        smp_req    = o_MemReq;
        smp_acc    = o_MemReq & i_MemReady;
        smp_valid  = o_InstrValid;
        smp_addr   = o_MemAddr;
        smp_rvalid = i_MemRValid;
        smp_stallf = o_StallF;

        checks++;
        if (o_StallF !== ~(o_MemReq & i_MemReady)) begin
            errors++;
            $display("FAIL stallf: got %b expected %b", o_StallF, ~(o_MemReq & i_MemReady));
        end
        if (o_MemReq) begin
            checks++;
            if (o_MemAddr !== i_PCF) begin
                errors++;
                $display("FAIL mem_addr: got %h expected %h", o_MemAddr, i_PCF);
            end
        end
        if (flush) begin
            checks++;
            if (o_MemReq !== 1'b0) begin
                errors++;
                $display("FAIL req_during_flush: got %b expected 0", o_MemReq);
            end
        end
        checks++;
        if (o_InstrValid !== (exp_q.size() != 0)) begin
            errors++;
            $display("FAIL instr_valid: got %b expected %b", o_InstrValid, exp_q.size() != 0);
        end else if (exp_q.size() != 0) begin
            checks++;
            if ({o_PCD, o_InstrD} !== exp_q[0]) begin
                errors++;
                $display("FAIL head: got pc=%h instr=%h expected pc=%h instr=%h",
                         o_PCD, o_InstrD, exp_q[0][63:32], exp_q[0][31:0]);
            end
        end else begin
            checks++;
            if (o_InstrD !== NOP || o_PCD !== 32'h0) begin
                errors++;
                $display("FAIL empty_out: got pc=%h instr=%h expected pc=0 instr=%h",
                         o_PCD, o_InstrD, NOP);
            end
        end

        if (flush) begin
            exp_q.delete();
        end else if (exp_q.size() != 0 && !stall_d) begin
            void'(exp_q.pop_front());
            pops++;
        end

        if (i_MemRValid) begin
            if (!flush && !mem_stale) exp_q.push_back({mem_pc, mem_data});
            mem_busy  = 1'b0;
            mem_stale = 1'b0;
        end else if (mem_busy) begin
            mem_cnt--;
            if (flush) mem_stale = 1'b1;
        end

        if (o_MemReq && i_MemReady) begin
            checks++;
            if (mem_busy) begin
                errors++;
                $display("FAIL outstanding: got 2 requests expected at most 1");
            end
            mem_busy  = 1'b1;
            mem_stale = 1'b0;
            mem_cnt   = latency - 1;
            mem_pc    = i_PCF;
            mem_data  = use_forced ? forced_data : $urandom();
        end
        if (!o_StallF) pcf = pcf + 32'd4;
        @(posedge i_Clk);
        #1;
    endtask

    // Assert reset asynchronously and check every output holds its reset value.
    task automatic reset_outputs(input string tag);
        i_MemReady = 1'b1;
        i_Reset    = 1'b0;
        exp_q.delete();
        if (mem_busy) mem_stale = 1'b1;
        #2;
        checks++;
        if (o_MemReq !== 1'b0 || o_StallF !== 1'b1 || o_InstrValid !== 1'b0 ||
            o_InstrD !== NOP || o_PCD !== 32'h0) begin
            errors++;
            $display("FAIL %s: got req=%b stallf=%b valid=%b instr=%h pc=%h expected 0 1 0 %h 0",
                     tag, o_MemReq, o_StallF, o_InstrValid, o_InstrD, o_PCD, NOP);
        end
        @(posedge i_Clk);
        #1;
        checks++;
        if (o_MemReq !== 1'b0 || o_InstrValid !== 1'b0) begin
            errors++;
            $display("FAIL %s_held: got req=%b valid=%b expected 0 0", tag, o_MemReq, o_InstrValid);
        end
        i_Reset = 1'b1;
    endtask

    task automatic drain();
        ready   = 1'b0;
        stall_d = 1'b0;
        flush   = 1'b0;
        for (int i = 0; i < 30 && (mem_busy || exp_q.size() != 0); i++) tick();
        checks++;
        if (mem_busy || exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got busy=%b queued=%0d expected 0 0", mem_busy, exp_q.size());
        end
    endtask

    task automatic test_reset();
        reset_outputs("reset");
    endtask

    task automatic test_zero_wait();
        logic [5:0] pat;
        pcf = 32'h0; ready = 1'b1; latency = 1; stall_d = 1'b0; pops = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            pat[i] = smp_acc;
        end
        checks++;
        if (pat !== 6'b010101) begin
            errors++;
            $display("FAIL zw_alternate: got %b expected 010101", pat);
        end
        drain();
        checks++;
        if (pops != 3) begin
            errors++;
            $display("FAIL zw_pops: got %0d expected 3", pops);
        end
    endtask

    task automatic test_stall_full();
        ready = 1'b1; latency = 1; stall_d = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (smp_req !== 1'b0 || smp_stallf !== 1'b1 || smp_valid !== 1'b1) begin
            errors++;
            $display("FAIL full_hold: got req=%b stallf=%b valid=%b expected 0 1 1",
                     smp_req, smp_stallf, smp_valid);
        end
        stall_d = 1'b0;
        tick();
        checks++;
        if (smp_req !== 1'b0) begin
            errors++;
            $display("FAIL full_pop_cycle: got req=%b expected 0", smp_req);
        end
        stall_d = 1'b1;
        tick();
        checks++;
        if (smp_acc !== 1'b1) begin
            errors++;
            $display("FAIL full_reissue: got accept=%b expected 1", smp_acc);
        end
        drain();
    endtask

    task automatic test_flush_drop();
        latency = 4; use_forced = 1'b1; forced_data = 32'hDEADBEEF;
        ready = 1'b1; stall_d = 1'b0;
        tick();
        ready = 1'b0;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; pcf = 32'h100; ready = 1'b1; use_forced = 1'b0;
        tick();
        checks++;
        if (smp_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_req: got %b expected 0", smp_req);
        end
        tick();
        checks++;
        if (smp_rvalid !== 1'b1 || smp_req !== 1'b0) begin
            errors++;
            $display("FAIL drop_resp: got rvalid=%b req=%b expected 1 0", smp_rvalid, smp_req);
        end
        tick();
        checks++;
        if (smp_acc !== 1'b1 || smp_addr !== 32'h100 || smp_valid !== 1'b0) begin
            errors++;
            $display("FAIL drop_reissue: got acc=%b addr=%h valid=%b expected 1 00000100 0",
                     smp_acc, smp_addr, smp_valid);
        end
        drain();
    endtask

    task automatic test_flush_with_rvalid();
        latency = 1; stall_d = 1'b1; ready = 1'b1;
        tick();
        tick();
        tick();
        flush = 1'b1;
        tick();
        checks++;
        if (smp_rvalid !== 1'b1 || smp_valid !== 1'b1) begin
            errors++;
            $display("FAIL fr_setup: got rvalid=%b valid=%b expected 1 1", smp_rvalid, smp_valid);
        end
        flush = 1'b0; pcf = 32'h200;
        tick();
        checks++;
        if (smp_valid !== 1'b0 || smp_acc !== 1'b1 || smp_addr !== 32'h200) begin
            errors++;
            $display("FAIL fr_after: got valid=%b acc=%b addr=%h expected 0 1 00000200",
                     smp_valid, smp_acc, smp_addr);
        end
        drain();
    endtask

    task automatic test_push_pop_wrap();
        int  n = 0;
        logic prev_pp = 1'b0;
        latency = 1; ready = 1'b1; stall_d = 1'b1;
        tick();
        tick();
        for (int i = 0; i < 40 && (n < 5 || prev_pp); i++) begin
            stall_d = !(mem_busy && mem_cnt == 0);
            tick();
            if (prev_pp) begin
                checks++;
                if (smp_valid !== 1'b1) begin
                    errors++;
                    $display("FAIL pp_count: got valid=%b expected 1", smp_valid);
                end
            end
            prev_pp = smp_rvalid;
            if (smp_rvalid) n++;
        end
        checks++;
        if (n < 5) begin
            errors++;
            $display("FAIL pp_timeout: got %0d push-pop cycles expected 5", n);
        end
        drain();
    endtask

    task automatic test_reset_mid();
        latency = 3; ready = 1'b1; stall_d = 1'b0;
        tick();
        ready = 1'b0;
        tick();
        reset_outputs("reset_mid");
        mem_cnt = 0;
        tick();
        checks++;
        if (smp_rvalid !== 1'b1 || smp_acc !== 1'b0) begin
            errors++;
            $display("FAIL rm_stale: got rvalid=%b acc=%b expected 1 0", smp_rvalid, smp_acc);
        end
        tick();
        checks++;
        if (smp_valid !== 1'b0 || smp_req !== 1'b1) begin
            errors++;
            $display("FAIL rm_ignored: got valid=%b req=%b expected 0 1", smp_valid, smp_req);
        end
        pcf = 32'h300; ready = 1'b1;
        tick();
        checks++;
        if (smp_acc !== 1'b1 || smp_addr !== 32'h300) begin
            errors++;
            $display("FAIL rm_first_req: got acc=%b addr=%h expected 1 00000300", smp_acc, smp_addr);
        end
        drain();
    endtask

    initial begin
        pcf = '0; ready = 1'b0; stall_d = 1'b0; flush = 1'b0; latency = 1;
        mem_busy = 1'b0; mem_stale = 1'b0; mem_cnt = 0; mem_pc = '0; mem_data = '0;
        use_forced = 1'b0; forced_data = '0; pops = 0;
        @(posedge i_Clk);
        #1;
        test_reset();
        test_zero_wait();
        test_stall_full();
        test_flush_drop();
        test_flush_with_rvalid();
        test_push_pop_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
